conv_layer_output_interface: RTL and testbench
==============================================

Name: conv_layer_output_interface

Overview:
- Drain side of the conv layer: the counterpart of the input interface that loads pixels into the kernel array.
- Accepts 6-wide parallel feature rows (ARRAY_SIZE x 32-bit IEEE-754) from conv_kernel_array and buffers up to two rows.
- Serialises each row into a single 32-bit stream with valid/ready and a feature-RAM write address.
- Signals completion of a full OUT_ROWS x ARRAY_SIZE feature map to conv_layer_controller.

Parameters:
- WIDTH, 32, bits per feature word
- ARRAY_SIZE, 6, words per parallel row (kernel array width)
- OUT_ROWS, 6, rows per feature map (IMAGE_SIZE-KERNEL_SIZE+1)
- ADDR_WIDTH, 8, write-address width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  start a frame (sampled in IDLE only)
- i_feature_bus  input  ARRAY_SIZE*WIDTH  row from kernel array; word 0 = bits [ARRAY_SIZE*WIDTH-1 -: WIDTH]
- i_bus_valid  input  1  row present
- o_bus_ready  output  1  row accepted when valid&&ready at clk edge
- o_pixel  output  WIDTH  serial feature word
- o_pixel_valid  output  1  o_pixel valid
- i_pixel_ready  input  1  downstream accepts word
- o_wr_addr  output  ADDR_WIDTH  address of current o_pixel = row*ARRAY_SIZE+col
- o_frame_done  output  1  one-cycle pulse after last word of frame
- current_state  output  2  FSM state (IDLE=0, SEND=1, DONE=2)

Behaviour:
- Reset (async, rst_n=0): state IDLE. o_bus_ready=0, o_pixel_valid=0, o_pixel=0, o_wr_addr=0, o_frame_done=0. Buffer slots cleared, occupancy=0, all counters 0. Reset mid-frame drops buffered rows; no partial output afterwards.
- IDLE: o_bus_ready=0. enable=1 -> SEND next edge; clear col, out_row and in_row counters.
- SEND, input side:
  - o_bus_ready = (occupancy<2) && (in_row<OUT_ROWS).
  - On accept, the bus is written to the tail slot and in_row increments.
  - Ready is low when occupancy==2, even if a pop occurs in the same cycle.
- SEND, output side:
  - o_pixel_valid = (occupancy>0). o_pixel = head slot word[col], a combinational mux from registered slots. o_wr_addr = out_row*ARRAY_SIZE+col.
  - Word transfers when o_pixel_valid && i_pixel_ready: col increments.
  - At col==ARRAY_SIZE-1: col->0, head slot popped, out_row increments.
  - While i_pixel_ready=0, o_pixel, o_pixel_valid and o_wr_addr hold stable.
- Simultaneous accept and pop in one cycle: occupancy unchanged, slot pointers both advance (2-entry ring, 1-bit pointers wrap).
- Latency: a row accepted at edge N into an empty buffer gives o_pixel_valid=1 with word 0 during cycle N+1. With i_pixel_ready held high, a full row drains in ARRAY_SIZE cycles. Back-to-back rows stream with no bubble.
- Frame end: the transfer of word ARRAY_SIZE-1 of row OUT_ROWS-1 (addr 35 by default) -> DONE. In DONE, o_frame_done=1 for exactly one cycle, then -> IDLE. o_bus_ready=0 in DONE and IDLE.
- i_bus_valid while in_row==OUT_ROWS is ignored (ready low). Extra rows are never consumed.
- enable is ignored outside IDLE. Deasserting it mid-frame does not abort the frame. enable held high restarts a new frame after DONE->IDLE->SEND, so the minimum gap between frames is 2 cycles.
- Data is passed bit-exact; no arithmetic on feature words. o_wr_addr max = OUT_ROWS*ARRAY_SIZE-1 and never wraps within a frame.

Test Plan:
- Single row: enable pulse, one row 0x3F800000..0x40C00000 (1.0..6.0), i_pixel_ready=1 -> six words in order 1.0..6.0 on consecutive cycles starting 1 cycle after accept, addr 0..5.
- Backpressure: i_pixel_ready toggles 1,0,0,1 -> o_pixel, o_wr_addr and o_pixel_valid stable during stalls; no word lost or duplicated.
- Full frame streaming: 6 rows with i_bus_valid held high, ready high -> 36 words, addr 0..35 contiguous, o_frame_done pulses one cycle after addr 35, state DONE->IDLE.
- Buffer full: i_pixel_ready=0, offer 3 rows -> first two accepted, o_bus_ready=0 for the third until the first row fully drains.
- Overrun: 7th row offered after 6 accepted -> never accepted; frame completes normally.
- Reset mid-frame: assert rst_n=0 at addr 17 -> all outputs 0 immediately; after release with enable, new frame starts at addr 0.

Source files
------------

// File: rtl/conv_layer_output_interface.sv
// conv_layer_output_interface: buffers up to two parallel feature rows and
// serialises them into a 32-bit valid/ready stream with feature-RAM addresses.
`default_nettype none

module conv_layer_output_interface #(
    parameter int WIDTH      = 32,
    parameter int ARRAY_SIZE = 6,
    parameter int OUT_ROWS   = 6,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [ARRAY_SIZE*WIDTH-1:0]   i_feature_bus,
    input  logic                          i_bus_valid,
    output logic                          o_bus_ready,
    output logic [WIDTH-1:0]              o_pixel,
    output logic                          o_pixel_valid,
    input  logic                          i_pixel_ready,
    output logic [ADDR_WIDTH-1:0]         o_wr_addr,
    output logic                          o_frame_done,
    output logic [1:0]                    current_state
);

    localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int ROW_W = $clog2(OUT_ROWS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state;
    logic [ARRAY_SIZE*WIDTH-1:0]   slot [2];
    logic                          head;
    logic                          tail;
    logic [1:0]                    occ;
    logic [COL_W-1:0]              col;
    logic [ROW_W-1:0]              out_row;
    logic [ROW_W-1:0]              in_row;
    logic [WIDTH-1:0]              head_words [ARRAY_SIZE];

    logic accept;
    logic xfer;
    logic last_word;
    logic pop;

    // Word 0 sits in the most significant lane of the bus.
    always_comb begin
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            head_words[k] = slot[head][(ARRAY_SIZE-1-k)*WIDTH +: WIDTH];
        end
    end

    assign o_bus_ready   = (state == SEND) && (occ != 2'd2) && (in_row < ROW_W'(OUT_ROWS));
    assign o_pixel_valid = (state == SEND) && (occ != 2'd0);
    assign o_pixel       = o_pixel_valid ? head_words[col] : '0;
    assign o_wr_addr     = ADDR_WIDTH'(out_row) * ADDR_WIDTH'(ARRAY_SIZE) + ADDR_WIDTH'(col);
    assign o_frame_done  = (state == DONE);
    assign current_state = state;

    assign accept    = o_bus_ready && i_bus_valid;
    assign xfer      = o_pixel_valid && i_pixel_ready;
    assign last_word = (col == COL_W'(ARRAY_SIZE - 1));
    assign pop       = xfer && last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            slot[0] <= '0;
            slot[1] <= '0;
            head    <= 1'b0;
            tail    <= 1'b0;
            occ     <= 2'd0;
            col     <= '0;
            out_row <= '0;
            in_row  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= SEND;
                        col     <= '0;
                        out_row <= '0;
                        in_row  <= '0;
                    end
                end
                SEND: begin
                    if (accept) begin
                        slot[tail] <= i_feature_bus;
                        tail       <= ~tail;
                        in_row     <= in_row + 1'b1;
                    end
                    if (xfer) begin
                        if (last_word) begin
                            col     <= '0;
                            head    <= ~head;
                            out_row <= out_row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    case ({accept, pop})
                        2'b10:   occ <= occ + 2'd1;
                        2'b01:   occ <= occ - 2'd1;
                        default: occ <= occ;
                    endcase
                    // Last word of the frame: park counters so the address idles at 0.
                    if (pop && (out_row == ROW_W'(OUT_ROWS - 1))) begin
                        state   <= DONE;
                        col     <= '0;
                        out_row <= '0;
                        in_row  <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_layer_output_interface.sv
// Randomised bench for conv_layer_output_interface against a queue-based row model.
`default_nettype none

module tb_conv_layer_output_interface;

    localparam int W  = 32;
    localparam int N  = 6;
    localparam int R  = 6;
    localparam int AW = 8;

    typedef logic [N*W-1:0] row_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [N*W-1:0]  i_feature_bus = '0;
    logic            i_bus_valid = 1'b0;
    logic            o_bus_ready;
    logic [W-1:0]    o_pixel;
    logic            o_pixel_valid;
    logic            i_pixel_ready = 1'b0;
    logic [AW-1:0]   o_wr_addr;
    logic            o_frame_done;
    logic [1:0]      current_state;

    conv_layer_output_interface #(
        .WIDTH(W), .ARRAY_SIZE(N), .OUT_ROWS(R), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .i_feature_bus(i_feature_bus), .i_bus_valid(i_bus_valid), .o_bus_ready(o_bus_ready),
        .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid), .i_pixel_ready(i_pixel_ready),
        .o_wr_addr(o_wr_addr), .o_frame_done(o_frame_done), .current_state(current_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int frames = 0;

    // Reference: rows waiting to be emitted, plus frame position counters.
    row_t q[$];
    int   m_state = 0;
    int   m_col = 0;
    int   m_out = 0;
    int   m_in = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_valid();
        return (m_state == 1) && (q.size() > 0);
    endfunction

    task automatic check_outputs();
        row_t r;
        logic [W-1:0] w;
        check_eq("state", 64'(current_state), 64'(m_state));
        check_eq("bus_ready", 64'(o_bus_ready),
                 64'((m_state == 1) && (q.size() < 2) && (m_in < R)));
        check_eq("pixel_valid", 64'(o_pixel_valid), 64'(exp_valid()));
        check_eq("frame_done", 64'(o_frame_done), 64'(m_state == 2));
        if (exp_valid()) begin
            r = q[0];
            w = r[(N-1-m_col)*W +: W];
            check_eq("pixel", 64'(o_pixel), 64'(w));
            check_eq("wr_addr", 64'(o_wr_addr), 64'(m_out*N + m_col));
        end
    endtask

    task automatic model_step();
        bit rdy;
        rdy = (q.size() < 2) && (m_in < R);
        case (m_state)
            0: if (enable) begin
                m_state = 1; m_col = 0; m_out = 0; m_in = 0;
            end
            1: begin
                if (exp_valid() && i_pixel_ready) begin
                    if (m_col == N-1) begin
                        void'(q.pop_front());
                        m_col = 0;
                        m_out++;
                        if (m_out == R) begin
                            m_state = 2;
                            frames++;
                        end
                    end else begin
                        m_col++;
                    end
                end
                if (rdy && i_bus_valid) begin
                    q.push_back(i_feature_bus);
                    m_in++;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic tick();
        check_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit en, input bit v, input bit pr);
        enable = en;
        i_bus_valid = v;
        i_pixel_ready = pr;
        if (v) begin
            for (int k = 0; k < N; k++) i_feature_bus[k*W +: W] = $urandom;
        end
        tick();
    endtask

    task automatic check_reset_zero();
        check_eq("rst_state", 64'(current_state), 64'd0);
        check_eq("rst_bus_ready", 64'(o_bus_ready), 64'd0);
        check_eq("rst_pixel_valid", 64'(o_pixel_valid), 64'd0);
        check_eq("rst_pixel", 64'(o_pixel), 64'd0);
        check_eq("rst_wr_addr", 64'(o_wr_addr), 64'd0);
        check_eq("rst_frame_done", 64'(o_frame_done), 64'd0);
    endtask

    initial begin
        bit pat [4];
        bit hit;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check_reset_zero();
        rst_n = 1'b1;
        @(negedge clk);

        // Single directed row 1.0 .. 6.0
        drive(1'b1, 1'b0, 1'b1);
        enable = 1'b0;
        i_bus_valid = 1'b1;
        i_pixel_ready = 1'b1;
        i_feature_bus = {32'h3F800000, 32'h40000000, 32'h40400000,
                         32'h40800000, 32'h40A00000, 32'h40C00000};
        tick();
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1);

        // Backpressure pattern 1,0,0,1 while the rest of the frame arrives
        for (int i = 0; i < 90; i++) drive(1'b0, 1'b1, pat[i % 4]);

        // Streaming with enable held high: back-to-back frames
        for (int i = 0; i < 90; i++) drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, 1'b1);

        // Buffer full: downstream stalled, rows offered continuously
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++) drive(1'b0, 1'b1, 1'b1);

        // Random traffic including overrun offers
        for (int i = 0; i < 800; i++)
            drive(($urandom % 8) == 0, $urandom % 2, ($urandom % 4) != 0);

        // Reset mid-frame at address 17
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (exp_valid() && (m_out*N + m_col == 17)) hit = 1'b1;
            else drive(1'b0, $urandom % 2, $urandom % 2);
        end
        check_eq("reach_addr17", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_zero();
        q.delete();
        m_state = 0; m_col = 0; m_out = 0; m_in = 0;
        @(negedge clk);
        check_reset_zero();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++)
            drive(1'b0, ($urandom % 3) != 0, ($urandom % 4) != 0);

        check_eq("frames_completed_nonzero", 64'(frames >= 4), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
